// File: rtl/ascii_pkg.sv
`default_nettype none
// ==========================================================================
// ascii_pkg: shared constants and host FSM state type for the ASCII TX path.
// Revision 1.0
// ==========================================================================
package ascii_pkg;

   localparam logic [7:0] ASCII_CR      = 8'h0D;
   localparam logic [7:0] ASCII_LF      = 8'h0A;
   localparam int         DEFAULT_DEPTH = 16;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } host_state_t;

   // Stored form of a CPU byte: 7-bit ASCII, carriage return folded to line feed.
   function automatic logic [7:0] tx_translate(input logic [7:0] i_byte);
      logic [7:0] w_char;
      w_char = i_byte & 8'h7F;
      return (w_char == ASCII_CR) ? ASCII_LF : w_char;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ascii_fifo.sv
`default_nettype none
// ==========================================================================
// ascii_fifo: single-clock byte FIFO with registered count and full/empty flags.
// Revision 1.0
// ==========================================================================
module ascii_fifo #(
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [7:0]    i_data,
   output logic [7:0]    o_head,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_full;
   logic          r_empty;

   logic          w_pop;
   logic          w_push;
   logic [CW-1:0] w_count_nxt;

   // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
   assign w_pop       = i_pop & ~r_empty;
   assign w_push      = i_push & (~r_full | w_pop);
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = r_full;
   assign o_empty = r_empty;
   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ascii_output.sv
`default_nettype none
// ==========================================================================
// ascii_output: CPU TX register pair feeding a FIFO drained by the host upload port.
// Revision 1.0
// ==========================================================================
module ascii_output
   import ascii_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic        clk25,
   input  logic        rst_n,
   input  logic        cs,
   input  logic        we,
   input  logic        address,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   input  logic        ioctl_upload,
   input  logic        ioctl_rd,
   output logic [7:0]  ioctl_din,
   output logic [13:0] ioctl_addr,
   output logic        data_avail
);

   localparam int CW = $clog2(DEPTH) + 1;

   host_state_t   r_state;
   host_state_t   w_state_nxt;
   logic          w_enter;

   logic [7:0]    r_dout;
   logic [7:0]    r_ioctl_din;
   logic [13:0]   r_ioctl_addr;
   logic          r_overflow;

   logic          w_wr_data;
   logic          w_wr_stat;
   logic          w_rd_data;
   logic          w_rd_stat;
   logic          w_host_rd;
   logic          w_pop;
   logic          w_drop;
   logic [7:0]    w_push_data;
   logic [7:0]    w_head;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic [8:0]    w_count_ext;
   logic [4:0]    w_count_sat;

   assign w_wr_data   = cs &  we & ~address;
   assign w_wr_stat   = cs &  we &  address;
   assign w_rd_data   = cs & ~we & ~address;
   assign w_rd_stat   = cs & ~we &  address;
   assign w_host_rd   = (r_state == XFER) & ioctl_rd;
   assign w_pop       = w_host_rd & ~w_empty;
   assign w_drop      = w_wr_data & w_full & ~w_pop;
   assign w_push_data = tx_translate(din);

   ascii_fifo #(
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk     (clk25),
      .rst_n   (rst_n),
      .i_push  (w_wr_data),
      .i_pop   (w_host_rd),
      .i_data  (w_push_data),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Count is up to 9 bits wide; the status field only has room for 0..31.
   always_comb begin
      w_count_ext            = '0;
      w_count_ext[CW-1:0]    = w_count;
      w_count_sat            = (w_count_ext > 9'd31) ? 5'd31 : w_count_ext[4:0];
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         r_dout     <= 8'h00;
         r_overflow <= 1'b0;
      end else begin
         if (w_rd_data)      r_dout <= {w_full, 7'b0};
         else if (w_rd_stat) r_dout <= {w_full, w_empty, r_overflow, w_count_sat};

         if (w_wr_stat)      r_overflow <= 1'b0;
         else if (w_drop)    r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_enter     = 1'b0;
      case (r_state)
         IDLE: if (ioctl_upload) begin
                  w_state_nxt = XFER;
                  w_enter     = 1'b1;
               end
         XFER: if (!ioctl_upload) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Address is preloaded to all-ones so the first returned byte reports index 0.
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         r_ioctl_din  <= 8'h00;
         r_ioctl_addr <= 14'd0;
      end else if (w_enter) begin
         r_ioctl_addr <= 14'h3FFF;
      end else if (w_host_rd) begin
         r_ioctl_din  <= w_empty ? 8'h00 : w_head;
         r_ioctl_addr <= r_ioctl_addr + 14'd1;
      end
   end

   assign dout       = r_dout;
   assign ioctl_din  = r_ioctl_din;
   assign ioctl_addr = r_ioctl_addr;
   assign data_avail = ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_ascii_output.sv
`default_nettype none
// Testbench for ascii_output: vector table, directed corner sequences and random traffic vs a queue model.
module tb_ascii_output;

   localparam int DEPTH = 16;

   logic        clk25 = 1'b0;
   logic        rst_n = 1'b0;
   logic        cs = 1'b0, we = 1'b0, address = 1'b0;
   logic [7:0]  din = 8'h00;
   logic [7:0]  dout;
   logic        ioctl_upload = 1'b0, ioctl_rd = 1'b0;
   logic [7:0]  ioctl_din;
   logic [13:0] ioctl_addr;
   logic        data_avail;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [7:0] mq[$];
   bit         m_ovf  = 1'b0;
   bit         m_xfer = 1'b0;
   int         m_addr = 0;
   logic [7:0] m_dout = 8'h00;
   logic [7:0] m_idin = 8'h00;

   always #20 clk25 = ~clk25;

   ascii_output #(.DEPTH(DEPTH)) dut (
      .clk25        (clk25),
      .rst_n        (rst_n),
      .cs           (cs),
      .we           (we),
      .address      (address),
      .din          (din),
      .dout         (dout),
      .ioctl_upload (ioctl_upload),
      .ioctl_rd     (ioctl_rd),
      .ioctl_din    (ioctl_din),
      .ioctl_addr   (ioctl_addr),
      .data_avail   (data_avail)
   );

   typedef struct {
      logic       cs, we, a;
      logic [7:0] din;
      logic       up, rd;
      logic [7:0] e_dout, e_idin;
      logic [13:0] e_iaddr;
      logic       e_avail;
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] xlate(input logic [7:0] d);
      logic [7:0] b;
      b = d % 8'd128;
      if (b == 8'd13) b = 8'd10;
      return b;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_ovf = 0; m_xfer = 0; m_addr = 0; m_dout = 8'h00; m_idin = 8'h00;
   endtask

   task automatic model_step(input logic c, w, a, input logic [7:0] d, input logic up, r);
      int  sz    = mq.size();
      bit  full  = (sz == DEPTH);
      bit  empty = (sz == 0);
      bit  hrd   = m_xfer && r;
      bit  pop   = hrd && !empty;
      int  cnt   = (sz > 31) ? 31 : sz;
      if (c && !w) m_dout = a ? {full, empty, m_ovf, 5'(cnt)} : {full, 7'b0};
      if (hrd) begin
         m_idin = empty ? 8'h00 : mq[0];
         m_addr = (m_addr + 1) % 16384;
      end
      if (pop) mq.delete(0);
      if (c && w && !a) begin
         if (!full || pop) mq.push_back(xlate(d));
         else m_ovf = 1;
      end
      if (c && w && a) m_ovf = 0;
      if (!m_xfer && up) begin
         m_xfer = 1; m_addr = 16383;
      end else if (m_xfer && !up) begin
         m_xfer = 0;
      end
   endtask

   task automatic cycle(input logic c, w, a, input logic [7:0] d, input logic up, r);
      cs = c; we = w; address = a; din = d; ioctl_upload = up; ioctl_rd = r;
      @(posedge clk25);
      model_step(c, w, a, d, up, r);
      #1;
      check("dout", 16'(dout), 16'(m_dout));
      check("ioctl_din", 16'(ioctl_din), 16'(m_idin));
      check("ioctl_addr", 16'(ioctl_addr), 16'(m_addr));
      check("data_avail", 16'(data_avail), 16'(mq.size() != 0));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_dout", 16'(dout), 16'h0);
      check("rst_ioctl_din", 16'(ioctl_din), 16'h0);
      check("rst_ioctl_addr", 16'(ioctl_addr), 16'h0);
      check("rst_data_avail", 16'(data_avail), 16'h0);
      @(posedge clk25);
      @(posedge clk25);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      logic up;
      tbl[0]  = '{1'b1,1'b1,1'b0,8'hC1,1'b0,1'b0, 8'h00,8'h00,14'd0,   1'b1};
      tbl[1]  = '{1'b1,1'b1,1'b0,8'h8D,1'b0,1'b0, 8'h00,8'h00,14'd0,   1'b1};
      tbl[2]  = '{1'b1,1'b1,1'b0,8'h42,1'b0,1'b0, 8'h00,8'h00,14'd0,   1'b1};
      tbl[3]  = '{1'b1,1'b0,1'b1,8'h00,1'b0,1'b0, 8'h03,8'h00,14'd0,   1'b1};
      tbl[4]  = '{1'b1,1'b0,1'b0,8'h00,1'b0,1'b0, 8'h00,8'h00,14'd0,   1'b1};
      tbl[5]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0, 8'h00,8'h00,14'h3FFF,1'b1};
      tbl[6]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1, 8'h00,8'h41,14'd0,   1'b1};
      tbl[7]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1, 8'h00,8'h0A,14'd1,   1'b1};
      tbl[8]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1, 8'h00,8'h42,14'd2,   1'b0};
      tbl[9]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b1, 8'h00,8'h00,14'd3,   1'b0};
      tbl[10] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0, 8'h00,8'h00,14'd3,   1'b0};
      tbl[11] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b1, 8'h00,8'h00,14'd3,   1'b0};
      tbl[12] = '{1'b1,1'b0,1'b1,8'h00,1'b0,1'b0, 8'h40,8'h00,14'd3,   1'b0};

      @(posedge clk25);
      #1;
      do_reset();

      // basic write / translate / upload sequence
      for (int i = 0; i < 13; i++) begin
         cycle(tbl[i].cs, tbl[i].we, tbl[i].a, tbl[i].din, tbl[i].up, tbl[i].rd);
         check($sformatf("tbl%0d_dout", i), 16'(dout), 16'(tbl[i].e_dout));
         check($sformatf("tbl%0d_idin", i), 16'(ioctl_din), 16'(tbl[i].e_idin));
         check($sformatf("tbl%0d_iaddr", i), 16'(ioctl_addr), 16'(tbl[i].e_iaddr));
         check($sformatf("tbl%0d_avail", i), 16'(data_avail), 16'(tbl[i].e_avail));
      end

      // overflow on the 17th write, then clear
      for (int i = 0; i < 17; i++) cycle(1, 1, 0, 8'h30 + 8'(i), 0, 0);
      cycle(1, 0, 1, 8'h00, 0, 0);
      check("ovf_status", 16'(dout), 16'h00B0);
      cycle(1, 0, 0, 8'h00, 0, 0);
      check("full_data_rd", 16'(dout), 16'h0080);
      cycle(1, 1, 1, 8'hFF, 0, 0);
      cycle(1, 0, 1, 8'h00, 0, 0);
      check("ovf_cleared", 16'(dout), 16'h0090);

      // push and pop together while full
      cycle(0, 0, 0, 8'h00, 1, 0);
      cycle(1, 1, 0, 8'h55, 1, 1);
      check("full_pushpop_head", 16'(ioctl_din), 16'h0030);
      cycle(1, 0, 1, 8'h00, 1, 0);
      check("full_pushpop_status", 16'(dout), 16'h0090);
      for (int i = 0; i < 16; i++) cycle(0, 0, 0, 8'h00, 1, 1);
      check("drain_last", 16'(ioctl_din), 16'h0055);
      cycle(0, 0, 0, 8'h00, 0, 0);

      // empty upload reads
      do_reset();
      cycle(0, 0, 0, 8'h00, 1, 0);
      cycle(0, 0, 0, 8'h00, 1, 1);
      cycle(0, 0, 0, 8'h00, 1, 1);
      check("empty_idin", 16'(ioctl_din), 16'h0000);
      check("empty_iaddr", 16'(ioctl_addr), 16'd1);
      check("empty_avail", 16'(data_avail), 16'd0);
      cycle(1, 1, 0, 8'h8D, 1, 1);
      check("empty_pushpop_idin", 16'(ioctl_din), 16'h0000);
      check("empty_pushpop_avail", 16'(data_avail), 16'd1);
      cycle(0, 0, 0, 8'h00, 1, 1);
      check("empty_pushpop_byte", 16'(ioctl_din), 16'h000A);

      // reset mid-upload with bytes queued
      for (int i = 0; i < 5; i++) cycle(1, 1, 0, 8'h61 + 8'(i), 1, 0);
      cycle(0, 0, 0, 8'h00, 1, 1);
      cs = 0; we = 0; ioctl_rd = 0;
      do_reset();
      cycle(1, 0, 1, 8'h00, 1, 0);
      check("post_rst_status", 16'(dout), 16'h0040);
      cycle(0, 0, 0, 8'h00, 1, 1);
      check("post_rst_iaddr", 16'(ioctl_addr), 16'd0);
      check("post_rst_idin", 16'(ioctl_din), 16'h0000);

      // alternating push/pop across pointer wrap
      for (int i = 0; i < 20; i++) begin
         cycle(1, 1, 0, 8'h60 + 8'(i), 1, 0);
         cycle(1, 0, 1, 8'h00, 1, 1);
         check("alt_count", 16'(dout & 8'h1F), 16'd1);
         check("alt_data", 16'(ioctl_din), 16'(8'h60 + 8'(i)));
      end

      // random traffic
      up = 1'b1;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 19) == 0) up = ~up;
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 4) == 0), 8'($urandom), up,
               1'($urandom_range(0, 2) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
